// File: rtl/dual_grant_issue.sv
// Two-channel grant issuer fed by an external dual priority encoder over the pending vector.
// Optional completed-handshake counter enabled by defining GRANT_CNT_EN.
module dual_grant_issue #(
    parameter int N = 12,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    input  logic         flush,
    output logic [N-1:0] pend,
    input  logic [M-1:0] first,
    input  logic [M-1:0] second,
    output logic         g0_valid,
    output logic [M-1:0] g0_code,
    input  logic         g0_ready,
    output logic         g1_valid,
    output logic [M-1:0] g1_code,
    input  logic         g1_ready,
    output logic [15:0]  gnt_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_e;

    ch_state_e    st0_q, st0_d, st1_q, st1_d;
    logic [M-1:0] code0_q, code0_d, code1_q, code1_d;
    logic [N-1:0] pend_q, pend_d, clr;
    logic [M-1:0] ch1_src;
    logic         free0, free1, ok_first, ok_second, load0, load1;

    // A code is loadable only if it is in range and its pending bit is actually set.
    function automatic logic code_ok(input logic [M-1:0] c, input logic [N-1:0] p);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < N; i++)
            if (c == M'(i + 1) && p[i]) ok = 1'b1;
        return ok;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [M-1:0] c);
        logic [N-1:0] oh;
        oh = '0;
        for (int i = 0; i < N; i++)
            if (c == M'(i + 1)) oh[i] = 1'b1;
        return oh;
    endfunction

    always_comb begin
        st0_d     = st0_q;
        st1_d     = st1_q;
        code0_d   = code0_q;
        code1_d   = code1_q;
        load0     = 1'b0;
        load1     = 1'b0;
        ch1_src   = first;
        free0     = (st0_q == EMPTY) || g0_ready;
        free1     = (st1_q == EMPTY) || g1_ready;
        ok_first  = code_ok(first, pend_q);
        ok_second = code_ok(second, pend_q) && (second != first);

        // A channel that stays full keeps its code; never load that same code into the other one.
        if (!flush) begin
            if (free0 && free1) begin
                load0   = ok_first;
                load1   = ok_second;
                ch1_src = second;
            end else if (free0) begin
                load0 = ok_first && (first != code1_q);
            end else if (free1) begin
                load1 = ok_first && (first != code0_q);
            end
        end

        if (free0) begin
            st0_d   = load0 ? FULL : EMPTY;
            code0_d = load0 ? first : '0;
        end
        if (free1) begin
            st1_d   = load1 ? FULL : EMPTY;
            code1_d = load1 ? ch1_src : '0;
        end

        clr = (load0 ? onehot(first) : '0) | (load1 ? onehot(ch1_src) : '0);
        // Set wins over clear: a request arriving as its code issues is kept for a later issue.
        pend_d = flush ? req_in : ((pend_q & ~clr) | req_in);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st0_q   <= EMPTY;
            st1_q   <= EMPTY;
            code0_q <= '0;
            code1_q <= '0;
            pend_q  <= '0;
        end else begin
            st0_q   <= st0_d;
            st1_q   <= st1_d;
            code0_q <= code0_d;
            code1_q <= code1_d;
            pend_q  <= pend_d;
        end
    end

    assign pend     = pend_q;
    assign g0_valid = (st0_q == FULL);
    assign g1_valid = (st1_q == FULL);
    assign g0_code  = code0_q;
    assign g1_code  = code1_q;

`ifdef GRANT_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    always_comb begin
        cnt_sum = {1'b0, cnt_q}
                + 17'((st0_q == FULL) && g0_ready)
                + 17'((st1_q == FULL) && g1_ready);
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign gnt_cnt = cnt_q;
`else
    assign gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_dual_grant_issue.sv
// Self-checking bench for dual_grant_issue: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of pending requests and two grant slots.
module tb_dual_grant_issue;
    localparam int N = 12;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_in;
    logic         flush;
    logic [N-1:0] pend;
    logic [M-1:0] first, second;
    logic         g0_valid, g1_valid, g0_ready, g1_ready;
    logic [M-1:0] g0_code, g1_code;
    logic [15:0]  gnt_cnt;
    logic         enc_bad;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] m_pend;
    logic         m_v [2];
    int           m_c [2];
    int           m_cnt;
    int           n7, nhi;

    dual_grant_issue #(.N(N), .M(M)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .flush(flush), .pend(pend),
        .first(first), .second(second),
        .g0_valid(g0_valid), .g0_code(g0_code), .g0_ready(g0_ready),
        .g1_valid(g1_valid), .g1_code(g1_code), .g1_ready(g1_ready),
        .gnt_cnt(gnt_cnt)
    );

    always #5 clk = ~clk;

    // Highest pending code other than 'skip' (0 when none).
    function automatic int top_code(input logic [N-1:0] p, input int skip);
        for (int i = N - 1; i >= 0; i--)
            if (p[i] && (i + 1) != skip) return i + 1;
        return 0;
    endfunction

    // External encoder; enc_bad forces out-of-range codes the DUT must ignore.
    always_comb begin
        first  = enc_bad ? 4'hF : 4'(top_code(pend, 0));
        second = enc_bad ? 4'hE : 4'(top_code(pend, top_code(pend, 0)));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic fl, input logic r0,
                              input logic r1, input logic bad, input logic rst);
        int f, s, l0, l1, hs;
        logic fr0, fr1;
        if (rst) begin
            m_pend = '0; m_v[0] = 0; m_v[1] = 0; m_c[0] = 0; m_c[1] = 0; m_cnt = 0;
            return;
        end
        f   = top_code(m_pend, 0);
        s   = top_code(m_pend, f);
        fr0 = !m_v[0] || r0;
        fr1 = !m_v[1] || r1;
        hs  = int'(m_v[0] && r0) + int'(m_v[1] && r1);
        l0  = 0;
        l1  = 0;
        if (!fl && !bad) begin
            if (fr0 && fr1) begin
                l0 = f; l1 = s;
            end else if (fr0) begin
                if (f != m_c[1]) l0 = f;
            end else if (fr1) begin
                if (f != m_c[0]) l1 = f;
            end
        end
        for (int i = 0; i < N; i++)
            if ((l0 != 0 && i + 1 == l0) || (l1 != 0 && i + 1 == l1)) m_pend[i] = 1'b0;
        m_pend = fl ? req : (m_pend | req);
        if (fr0) begin m_v[0] = (l0 != 0); m_c[0] = l0; end
        if (fr1) begin m_v[1] = (l1 != 0); m_c[1] = l1; end
`ifdef GRANT_CNT_EN
        m_cnt = (m_cnt + hs > 65535) ? 65535 : m_cnt + hs;
`else
        m_cnt = 0 * hs;
`endif
    endtask

    task automatic compare();
        chk("pend", 32'(pend), 32'(m_pend));
        chk("g0_valid", 32'(g0_valid), 32'(m_v[0]));
        chk("g1_valid", 32'(g1_valid), 32'(m_v[1]));
        if (m_v[0]) chk("g0_code", 32'(g0_code), 32'(m_c[0]));
        if (m_v[1]) chk("g1_code", 32'(g1_code), 32'(m_c[1]));
        chk("gnt_cnt", 32'(gnt_cnt), 32'(m_cnt));
        if (g0_valid && g1_valid) begin
            tests++;
            if (g0_code == g1_code) begin
                fails++;
                $display("FAIL dup_code: both channels hold %0d", g0_code);
            end
        end
    endtask

    task automatic step(input logic [N-1:0] req, input logic fl, input logic r0,
                        input logic r1, input logic bad, input logic rst);
        @(negedge clk);
        req_in = req; flush = fl; g0_ready = r0; g1_ready = r1; enc_bad = bad; rst_n = !rst;
        #1;
        if (!rst) begin
            if (g0_valid && r0) begin if (g0_code == 7) n7++; if (g0_code >= 9) nhi++; end
            if (g1_valid && r1) begin if (g1_code == 7) n7++; if (g1_code >= 9) nhi++; end
        end
        model_step(req, fl, r0, r1, bad, rst);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        logic [N-1:0] r;
        rst_n = 1'b0; req_in = '0; flush = 1'b0; g0_ready = 1'b0; g1_ready = 1'b0; enc_bad = 1'b0;
        n7 = 0; nhi = 0;

        // Reset with all requests asserted
        step(12'hFFF, 0, 1, 1, 0, 1);
        step(12'hFFF, 0, 1, 1, 0, 1);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_valids", {30'd0, g0_valid, g1_valid}, 0);
        chk("rst_codes", {24'd0, g0_code, g1_code}, 0);
        chk("rst_cnt", 32'(gnt_cnt), 0);

        // Dual issue
        step(12'h804, 0, 1, 1, 0, 0);
        chk("dual_pend_t1", 32'(pend), 32'h804);
        step(12'h000, 0, 1, 1, 0, 0);
        chk("dual_g0", 32'(g0_code), 12);
        chk("dual_g1", 32'(g1_code), 3);
        chk("dual_pend_t2", 32'(pend), 0);
        step(12'h000, 0, 1, 1, 0, 0);
`ifdef GRANT_CNT_EN
        chk("dual_cnt", 32'(gnt_cnt), 2);
`else
        chk("dual_cnt", 32'(gnt_cnt), 0);
`endif

        // Single request
        step(12'h001, 0, 1, 1, 0, 0);
        step(12'h000, 0, 1, 1, 0, 0);
        chk("single_g0", {31'd0, g0_valid} << 4 | 32'(g0_code), 32'h11);
        chk("single_g1v", 32'(g1_valid), 0);
        step(12'h000, 0, 1, 1, 0, 0);

        // Backpressure on channel 0
        step(12'h012, 0, 0, 1, 0, 0);
        step(12'h000, 0, 0, 1, 0, 0);
        chk("bp_g0", 32'(g0_code), 5);
        chk("bp_g1", 32'(g1_code), 2);
        step(12'h800, 0, 0, 1, 0, 0);
        chk("bp_g0_hold1", {31'd0, g0_valid} << 4 | 32'(g0_code), 32'h15);
        step(12'h000, 0, 0, 1, 0, 0);
        chk("bp_g0_hold2", {31'd0, g0_valid} << 4 | 32'(g0_code), 32'h15);
        chk("bp_g1_late", {31'd0, g1_valid} << 4 | 32'(g1_code), 32'h1C);
        step(12'h000, 0, 0, 1, 0, 0);
        chk("bp_g0_hold3", 32'(g0_code), 5);
        step(12'h000, 0, 1, 1, 0, 0);

        // Collision: re-request of code 7 while it issues
        n7 = 0;
        step(12'h040, 0, 1, 1, 0, 0);
        step(12'h040, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(12'h000, 0, 1, 1, 0, 0);
        chk("collision_n7", 32'(n7), 2);

        // Flush with both channels stalled
        step(12'h003, 0, 0, 0, 0, 0);
        step(12'h000, 0, 0, 0, 0, 0);
        step(12'hF00, 0, 0, 0, 0, 0);
        chk("flush_pre", 32'(pend), 32'hF00);
        step(12'h000, 1, 0, 0, 0, 0);
        chk("flush_pend", 32'(pend), 0);
        chk("flush_hold", {24'd0, g0_code, g1_code}, 32'h21);
        nhi = 0;
        for (int i = 0; i < 5; i++) step(12'h000, 0, 1, 1, 0, 0);
        chk("flush_nohi", 32'(nhi), 0);

        // Out-of-range encoder codes are ignored
        step(12'h010, 0, 1, 1, 0, 0);
        step(12'h000, 0, 1, 1, 1, 0);
        chk("bad_enc_pend", 32'(pend), 32'h010);
        step(12'h000, 0, 1, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = 12'($urandom) & 12'($urandom) & 12'($urandom);
            step(r, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dual_grant_issue.md
DUAL_GRANT_ISSUE -- requirements
Module: dual_grant_issue

Interface
REQ-001 SHALL have parameter: N, 12, request vector width.
REQ-002 SHALL have parameter: M, 4, code width; M >= log2(N+1).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port: req_in  input  N  request pulses; bit i set requests code i+1.
REQ-007 SHALL have port: flush  input  1  clear all pending, not-yet-issued requests.
REQ-008 SHALL have port: pend  output  N  registered pending vector; drives dual priority encoder "in".
REQ-009 SHALL have port: first  input  M  encoder highest pending code (1..N, 0 = none).
REQ-010 SHALL have port: second  input  M  encoder next-highest pending code (0 = none).
REQ-011 SHALL have port: g0_valid  output  1  channel 0 grant valid.
REQ-012 SHALL have port: g0_code  output  M  channel 0 granted code.
REQ-013 SHALL have port: g0_ready  input  1  channel 0 consumer accept.
REQ-014 SHALL have port: g1_valid / g1_code / g1_ready  output / output / input  1 / M / 1  channel 1, same semantics.
REQ-015 SHALL have port: gnt_cnt  output  16  completed-handshake count.

Function
REQ-016 SHALL update pend as pend_next = (pend & ~clr) | req_in, where clr = one-hot bits of codes loaded into channels this cycle.
REQ-017 SHALL, on a same-cycle set and clear of one bit, keep the bit set (set wins; the request is issued again later).
REQ-018 SHALL, when flush=1, set pend_next = req_in; in-flight channel contents are unaffected.
REQ-019 SHALL implement per-channel two-state FSM: EMPTY (valid=0), FULL (valid=1).
REQ-020 SHALL treat a channel as free when EMPTY, or when FULL with ready=1 (handshake completes this cycle).
REQ-021 SHALL, with both channels free, load ch0 from first and ch1 from second, each only if the code is nonzero.
REQ-022 SHALL, with only ch0 free, load ch0 from first; with only ch1 free, load ch1 from first.
REQ-023 SHALL move a free channel with nothing to load to EMPTY.
REQ-024 SHALL hold code and valid stable while FULL and ready=0.
REQ-025 SHALL give latency req_in pulse at edge t, pend at t+1, grant valid at t+2 when a channel is free.
REQ-026 SHALL never hold the same code in both channels, and never issue a code whose pend bit is 0.
REQ-027 SHALL ignore first/second values greater than N (no load, no clear).
REQ-028 SHALL ignore ready while valid=0.

Reset
REQ-029 SHALL, when rst_n=0 at a clock edge, clear pend=0, g0_valid=g1_valid=0, g0_code=g1_code=0, gnt_cnt=0; req_in is ignored that cycle.
REQ-030 SHALL, when reset is asserted mid-handshake, drop in-flight grants with no completion counted.

Configuration
REQ-031 SHALL support macro GRANT_CNT_EN: when defined, gnt_cnt increments by the number of handshakes completed per cycle (0, 1 or 2) and saturates at 16'hFFFF.
REQ-032 SHALL, when GRANT_CNT_EN is undefined, keep the gnt_cnt port present and tied to 0, with no counter logic.

Verification
REQ-033 SHALL verify reset: rst_n=0 two cycles, req_in=12'hFFF -> pend=0, both valids 0, gnt_cnt=0.
REQ-034 SHALL verify dual issue: req_in=12'h804 one cycle, both readies 1 -> t+2 g0_code=12, g1_code=3; pend=0 at t+2; gnt_cnt=2 at t+3 (cnt enabled).
REQ-035 SHALL verify single request: req_in=12'h001 -> g0_code=1, g1_valid stays 0.
REQ-036 SHALL verify backpressure: req_in=12'h012, g0_ready=0 for 5 cycles -> g0_code=5 stable throughout; g1 issues 2, then later request 12'h800 goes to g1 as 12 while g0 still stalled.
REQ-037 SHALL verify collision: bit 6 issued in the cycle req_in[6]=1 again -> code 7 granted twice in total.
REQ-038 SHALL verify flush: pend=12'hF00 with both channels stalled, flush=1 -> pend=0, stalled grants unchanged, no codes 9-12 issued afterward.
